// File: rtl/mac_fifo_ctrl.sv
// MAC operand circular buffer: push/pop gating, pointers, occupancy and registered read port.
// Full/empty disambiguation at equal pointers relies on the external Round wrap flag.
module mac_fifo_ctrl #(
  parameter int unsigned BufferWidth = 2,
  parameter int unsigned DataWidth   = 16
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   PushReq,
  input  logic                   PopReq,
  input  logic [DataWidth-1:0]   DataIn,
  input  logic                   Round,
  output logic                   Push,
  output logic                   Pop,
  output logic [BufferWidth-1:0] W_Addr,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   Full,
  output logic                   Empty,
  output logic [BufferWidth:0]   Level,
  output logic [DataWidth-1:0]   DataOut,
  output logic                   DataValid
);

  localparam int unsigned Depth       = 1 << BufferWidth;
  localparam int unsigned LevelWidth  = BufferWidth + 1;

  logic [DataWidth-1:0] mem [Depth];
  logic                 ptr_eq_c;

  // Status decodes only from registered pointers and Round, never from requests
  assign ptr_eq_c = (W_Addr == R_Addr);
  assign Full     = ptr_eq_c & Round;
  assign Empty    = ptr_eq_c & ~Round;
  assign Push     = PushReq & ~Full;
  assign Pop      = PopReq & ~Empty;

  // Storage is intentionally left unreset; reset still blocks a write in its cycle
  always_ff @(posedge clk) begin
    if (Push && !aclr) begin
      mem[W_Addr] <= DataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      W_Addr    <= '0;
      R_Addr    <= '0;
      Level     <= '0;
      DataOut   <= '0;
      DataValid <= 1'b0;
    end else begin
      if (Push) begin
        W_Addr <= W_Addr + BufferWidth'(1);
      end
      if (Pop) begin
        R_Addr  <= R_Addr + BufferWidth'(1);
        DataOut <= mem[R_Addr];
      end
      DataValid <= Pop;
      if (Push && !Pop) begin
        Level <= Level + LevelWidth'(1);
      end else if (Pop && !Push) begin
        Level <= Level - LevelWidth'(1);
      end
    end
  end

  a_full_empty_excl : assert property (@(posedge clk) disable iff (aclr) !(Full && Empty));
  a_level_ptr_diff  : assert property (@(posedge clk) disable iff (aclr)
                                       BufferWidth'(W_Addr - R_Addr) == Level[BufferWidth-1:0]);

endmodule
